alu_cmd_driver: RTL and testbench

Command-side front end for the 4-bit combinational ALU. It buffers operation requests in a small FIFO and issues them one at a time on the ALU's in1/in2/select inputs. It takes the ALU's five result buses plus carry/borrow, collapses them into a single result and flag, and returns them over a valid/ready response channel. It also flags illegal opcodes and ALU output-bus contract violations.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_cmd_fifo.sv | 66 ++++++
 rtl/alu_cmd_driver.sv | 139 +++++++++++++
 tb/tb_alu_cmd_driver.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and the command bundle
// for the ALU command front end.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
    } cmd_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO with registered full/empty
// flags and an occupancy count.
module alu_cmd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Next occupancy; push and pop together cancel.
    always_comb begin
        cnt_nxt = count;
        case ({do_push, do_pop})
            2'b10:   cnt_nxt = count + CNT_ONE;
            2'b01:   cnt_nxt = count - CNT_ONE;
            default: cnt_nxt = count;
        endcase
    end

    // Pointers wrap naturally; flags registered from next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= cnt_nxt;
            full  <= (cnt_nxt == CNT_FULL);
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Buffers ALU commands, issues them one at a time and
// returns the collapsed result over a valid/ready channel.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [2:0]             cmd_op,
    output logic [WIDTH-1:0]       alu_in1,
    output logic [WIDTH-1:0]       alu_in2,
    output logic [2:0]             alu_select,
    input  logic [WIDTH-1:0]       alu_and,
    input  logic [WIDTH-1:0]       alu_or,
    input  logic [WIDTH-1:0]       alu_sum,
    input  logic [WIDTH-1:0]       alu_sub,
    input  logic [WIDTH-1:0]       alu_xor,
    input  logic                   alu_carry,
    input  logic                   alu_borrow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_result,
    output logic                   rsp_flag,
    output logic [2:0]             rsp_op,
    output logic                   rsp_illegal,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   bus_err
);

    cmd_t             cmd_in;
    cmd_t             head;
    state_t           state;
    logic             full;
    logic             empty;
    logic             pop;
    logic [WIDTH-1:0] res;
    logic             flg;
    logic             ill;
    logic             viol;

    assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign cmd_ready = !full;
    assign pop       = (state == IDLE) && !empty;

    alu_cmd_fifo #(
        .DW    ($bits(cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (cmd_in),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Collapse the ALU buses for the issued op and check
    // that every unselected bus and flag is quiet.
    always_comb begin
        res = '0;
        flg = 1'b0;
        ill = 1'b0;
        unique case (1'b1)
            (alu_select == OP_ADD): begin
                res = alu_sum;
                flg = alu_carry;
            end
            (alu_select == OP_SUB): begin
                res = alu_sub;
                flg = alu_borrow;
            end
            (alu_select == OP_AND): res = alu_and;
            (alu_select == OP_OR):  res = alu_or;
            (alu_select == OP_XOR): res = alu_xor;
            default:                ill = 1'b1;
        endcase
        viol = ((alu_select != OP_ADD) && (|alu_sum))
            || ((alu_select != OP_SUB) && (|alu_sub))
            || ((alu_select != OP_AND) && (|alu_and))
            || ((alu_select != OP_OR)  && (|alu_or))
            || ((alu_select != OP_XOR) && (|alu_xor))
            || (!is_arith(alu_select)
                && (alu_carry || alu_borrow));
    end

    // Issue FSM: pop in IDLE, capture in ISSUE, hold in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_select  <= OP_IDLE;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flag    <= 1'b0;
            rsp_op      <= '0;
            rsp_illegal <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        alu_in1    <= head.a;
                        alu_in2    <= head.b;
                        alu_select <= head.op;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_result  <= res;
                    rsp_flag    <= flg;
                    rsp_illegal <= ill;
                    rsp_op      <= alu_select;
                    rsp_valid   <= 1'b1;
                    alu_select  <= OP_IDLE;
                    if (viol) bus_err <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural
// ALU and a response scoreboard.
module tb_alu_cmd_driver;

    typedef struct {
        logic [3:0] result;
        logic       flag;
        logic [2:0] op;
        logic       illegal;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0;
    logic [3:0] cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [3:0] alu_in1;
    logic [3:0] alu_in2;
    logic [2:0] alu_select;
    logic [3:0] alu_and;
    logic [3:0] alu_or;
    logic [3:0] alu_sum;
    logic [3:0] alu_sub;
    logic [3:0] alu_xor;
    logic       alu_carry;
    logic       alu_borrow;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_result;
    logic       rsp_flag;
    logic [2:0] rsp_op;
    logic       rsp_illegal;
    logic [2:0] fifo_count;
    logic       bus_err;

    logic       inject_or = 1'b0;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

    alu_cmd_driver #(.WIDTH(4), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_select  (alu_select),
        .alu_and     (alu_and),
        .alu_or      (alu_or),
        .alu_sum     (alu_sum),
        .alu_sub     (alu_sub),
        .alu_xor     (alu_xor),
        .alu_carry   (alu_carry),
        .alu_borrow  (alu_borrow),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flag    (rsp_flag),
        .rsp_op      (rsp_op),
        .rsp_illegal (rsp_illegal),
        .fifo_count  (fifo_count),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: only the selected bus is driven.
    always_comb begin
        alu_and    = '0;
        alu_or     = '0;
        alu_sum    = '0;
        alu_sub    = '0;
        alu_xor    = '0;
        alu_carry  = 1'b0;
        alu_borrow = 1'b0;
        case (alu_select)
            3'b000: {alu_carry, alu_sum} =
                {1'b0, alu_in1} + {1'b0, alu_in2};
            3'b001: begin
                alu_sub    = alu_in1 - alu_in2;
                alu_borrow = alu_in1 < alu_in2;
            end
            3'b010: alu_and = alu_in1 & alu_in2;
            3'b011: alu_or  = alu_in1 | alu_in2;
            3'b100: alu_xor = alu_in1 ^ alu_in2;
            default: ;
        endcase
        if (inject_or && alu_select == 3'b000) alu_or = 4'h1;
    end

    function automatic exp_t model(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [2:0] op
    );
        exp_t       e;
        logic [4:0] w;
        e.result  = '0;
        e.flag    = 1'b0;
        e.op      = op;
        e.illegal = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                e.result = w[3:0];
                e.flag   = w[4];
            end
            3'd1: begin
                e.result = a - b;
                e.flag   = (a < b);
            end
            3'd2: e.result = a & b;
            3'd3: e.result = a | b;
            3'd4: e.result = a ^ b;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge
    // after the accepting rising edge.
    task automatic send(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [2:0] op
    );
        int n = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("send_timeout", 32'(cmd_ready), 1);
        end else begin
            @(posedge clk);
            sb.push_back(model(a, b, op));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", 32'(rsp_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || rsp_valid) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_sb_empty", 32'(sb.size()), 0);
        rsp_ready = 1'b0;
    endtask

    // Compare each response as it is handshaken.
    always @(negedge clk) begin
        #1;
        if (!rst && rsp_valid && rsp_ready) begin
            check("rsp_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", 32'(rsp_result), 32'(e.result));
                check("rsp_flag", 32'(rsp_flag), 32'(e.flag));
                check("rsp_op", 32'(rsp_op), 32'(e.op));
                check("rsp_illegal", 32'(rsp_illegal),
                      32'(e.illegal));
            end
        end
    end

    initial begin
        int seen;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_select", 32'(alu_select), 3'b111);
        check("rst_in1", 32'(alu_in1), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_bus_err", 32'(bus_err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Add with carry and latency check
        send(4'h9, 4'h8, 3'b000);
        check("t1_valid_n0", 32'(rsp_valid), 0);
        @(negedge clk);
        check("t1_valid_n1", 32'(rsp_valid), 0);
        check("t1_issue_sel", 32'(alu_select), 3'b000);
        @(negedge clk);
        check("t1_valid_n2", 32'(rsp_valid), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t1_valid_clr", 32'(rsp_valid), 0);
        check("t1_result_hold", 32'(rsp_result), 4'h1);
        check("t1_select_idle", 32'(alu_select), 3'b111);

        // Sub with borrow held under backpressure
        send(4'h3, 4'h5, 3'b001);
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            check("t2_hold_valid", 32'(rsp_valid), 1);
            check("t2_hold_result", 32'(rsp_result), 4'hE);
            check("t2_hold_flag", 32'(rsp_flag), 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t2_valid_clr", 32'(rsp_valid), 0);

        // Fill the FIFO behind a stalled response
        send(4'hC, 4'hA, 3'b000);
        send(4'hC, 4'hA, 3'b010);
        send(4'hC, 4'hA, 3'b011);
        send(4'hC, 4'hA, 3'b100);
        send(4'hC, 4'hA, 3'b001);
        check("t3_full_ready", 32'(cmd_ready), 0);
        check("t3_full_count", 32'(fifo_count), 4);
        @(negedge clk);
        check("t3_still_full", 32'(cmd_ready), 0);
        rsp_ready = 1'b1;
        send(4'hA, 4'hC, 3'b001);
        drain();

        // Illegal opcode
        send(4'h5, 4'h3, 3'b110);
        @(negedge clk);
        check("t4_issue_sel", 32'(alu_select), 3'b110);
        wait_valid();
        drain();
        check("t4_bus_err", 32'(bus_err), 0);

        // Contract violation is sticky
        inject_or = 1'b1;
        send(4'h1, 4'h2, 3'b000);
        wait_valid();
        check("t5_bus_err_set", 32'(bus_err), 1);
        drain();
        inject_or = 1'b0;
        send(4'h7, 4'h7, 3'b010);
        drain();
        check("t5_bus_err_sticky", 32'(bus_err), 1);

        // Reset while a response is pending
        send(4'h1, 4'h1, 3'b000);
        send(4'h2, 4'h1, 3'b001);
        send(4'h3, 4'h1, 3'b011);
        wait_valid();
        check("t6_buffered", 32'(fifo_count), 2);
        rst = 1'b1;
        #1;
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_count", 32'(fifo_count), 0);
        check("t6_cmd_ready", 32'(cmd_ready), 1);
        check("t6_select", 32'(alu_select), 3'b111);
        check("t6_bus_err", 32'(bus_err), 0);
        check("t6_result", 32'(rsp_result), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("t6_no_rsp", 32'(seen), 0);
        rsp_ready = 1'b0;
        send(4'h6, 4'h3, 3'b100);
        wait_valid();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
